// File: rtl/laser_pkg.sv
// Shared types and helpers for the multi-channel laser pulse controller.
package laser_pkg;

    typedef enum logic [1:0] {
        L_IDLE,
        L_FIRE,
        L_COOL,
        L_WAIT_REL
    } laser_state_t;

    localparam int SHOT_W = 8;

    // Adding b to a never wraps: the result stops at the all-ones value.
    function automatic logic [SHOT_W-1:0] sat_add(input logic [SHOT_W-1:0] a,
                                                   input logic [3:0]        b);
        logic [SHOT_W:0] sum;
        sum = {1'b0, a} + (SHOT_W+1)'(b);
        return sum[SHOT_W] ? '1 : sum[SHOT_W-1:0];
    endfunction

endpackage

// File: rtl/laser_pulse_chan.sv
// One laser channel: fires for PULSE_CYCLES on grant, then locks out for COOLDOWN_CYCLES.
//  state      | meaning
//  L_IDLE     | waiting for a grant
//  L_FIRE     | laser on, counting down the pulse
//  L_COOL     | laser off, lockout countdown (also entered on abort)
//  L_WAIT_REL | lockout done but button still held; wait for release
module laser_pulse_chan
    import laser_pkg::*;
#(
    parameter int PULSE_CYCLES    = 3,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic grant,
    input  logic abort,
    input  logic button,
    output logic light,
    output logic busy,
    output logic firing
);

    laser_state_t     r_state;
    laser_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= L_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            L_IDLE: begin
                if (grant) begin
                    w_state_nxt = L_FIRE;
                    w_cnt_nxt   = CNT_W'(PULSE_CYCLES - 1);
                end
            end
            L_FIRE: begin
                // Abort cuts the pulse short but still imposes a full lockout.
                if (abort || r_cnt == '0) begin
                    w_state_nxt = L_COOL;
                    w_cnt_nxt   = CNT_W'(COOLDOWN_CYCLES - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            L_COOL: begin
                if (r_cnt == '0) begin
                    w_state_nxt = button ? L_WAIT_REL : L_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            L_WAIT_REL: begin
                if (!button) begin
                    w_state_nxt = L_IDLE;
                end
            end
            default: w_state_nxt = L_IDLE;
        endcase
    end

    assign light  = (r_state == L_FIRE);
    assign firing = (r_state == L_FIRE);
    assign busy   = (r_state == L_FIRE) || (r_state == L_COOL);

endmodule

// File: rtl/laser_pulse_ctrl.sv
// Multi-channel laser pulse controller: press detection, grant arbitration,
// saturating shot counter and one pulse FSM per channel.
module laser_pulse_ctrl
    import laser_pkg::*;
#(
    parameter int CHANNELS        = 2,
    parameter int PULSE_CYCLES    = 3,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int MUTEX           = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] button,
    input  logic                abort,
    output logic [CHANNELS-1:0] light,
    output logic [CHANNELS-1:0] busy,
    output logic [SHOT_W-1:0]   shot_count
);

    localparam int CNT_MAX = (PULSE_CYCLES > COOLDOWN_CYCLES) ? PULSE_CYCLES : COOLDOWN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CHANNELS-1:0] r_button_q;
    logic [SHOT_W-1:0]   r_shot_count;
    logic [CHANNELS-1:0] w_press;
    logic [CHANNELS-1:0] w_eligible;
    logic [CHANNELS-1:0] w_grant;
    logic [CHANNELS-1:0] w_firing;
    logic [3:0]          w_pop;

    // button_q resets high so a button held through reset needs a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_button_q   <= '1;
            r_shot_count <= '0;
        end else begin
            r_button_q   <= button;
            r_shot_count <= sat_add(r_shot_count, w_pop);
        end
    end

    assign w_press = button & ~r_button_q;

    // Presses on busy channels are dropped here so they never count as shots.
    always_comb begin
        w_eligible = w_press & ~busy;
        w_grant    = '0;
        if (!abort) begin
            if (MUTEX == 0) begin
                w_grant = w_eligible;
            end else if (w_firing == '0) begin
                w_grant = w_eligible & (~w_eligible + CHANNELS'(1));
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_pop = w_pop + 4'(w_grant[i]);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        laser_pulse_chan #(
            .PULSE_CYCLES   (PULSE_CYCLES),
            .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .grant (w_grant[g]),
            .abort (abort),
            .button(button[g]),
            .light (light[g]),
            .busy  (busy[g]),
            .firing(w_firing[g])
        );
    end

    assign shot_count = r_shot_count;

endmodule

// File: tb/tb_laser_pulse_ctrl.sv
// Bench for laser_pulse_ctrl: pulses on the default instance are checked by a scoreboard
// monitor; MUTEX=0 and single-cycle-pulse variants are checked directly.
module tb_laser_pulse_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] button, light, busy;
    logic       abort;
    logic [7:0] shot_count;

    logic [1:0] button_m0, light_m0, busy_m0;
    logic       abort_m0;
    logic [7:0] shot_m0;

    logic [0:0] button_p1, light_p1, busy_p1;
    logic [7:0] shot_p1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int ch;
        int len;
        int shots;
    } pulse_t;
    pulse_t exp_q[$];

    always #5 clk = ~clk;

    laser_pulse_ctrl #(.CHANNELS(2), .PULSE_CYCLES(3), .COOLDOWN_CYCLES(4), .MUTEX(1)) dut (
        .clk(clk), .rst(rst), .button(button), .abort(abort),
        .light(light), .busy(busy), .shot_count(shot_count)
    );

    laser_pulse_ctrl #(.CHANNELS(2), .PULSE_CYCLES(3), .COOLDOWN_CYCLES(4), .MUTEX(0)) dut_m0 (
        .clk(clk), .rst(rst), .button(button_m0), .abort(abort_m0),
        .light(light_m0), .busy(busy_m0), .shot_count(shot_m0)
    );

    laser_pulse_ctrl #(.CHANNELS(1), .PULSE_CYCLES(1), .COOLDOWN_CYCLES(4), .MUTEX(1)) dut_p1 (
        .clk(clk), .rst(rst), .button(button_p1), .abort(1'b0),
        .light(light_p1), .busy(busy_p1), .shot_count(shot_p1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int ch, input int len, input int shots);
        pulse_t p;
        p.ch    = ch;
        p.len   = len;
        p.shots = shots;
        exp_q.push_back(p);
    endtask

    // Monitor: measures every light pulse on the default instance and pops the scoreboard.
    logic [1:0] mon_prev = 2'b00;
    int         mon_len[2];
    int         mon_shots[2];
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (light[i] && !mon_prev[i]) begin
                    mon_len[i]   = 1;
                    mon_shots[i] = int'(shot_count);
                end else if (light[i]) begin
                    mon_len[i]++;
                end
                if (!light[i] && mon_prev[i]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pulse: ch=%0d len=%0d, none expected (t=%0t)",
                                 i, mon_len[i], $time);
                    end else begin
                        pulse_t e;
                        e = exp_q.pop_front();
                        chk("pulse_ch", i, e.ch);
                        chk("pulse_len", mon_len[i], e.len);
                        chk("pulse_shots", mon_shots[i], e.shots);
                    end
                end
                mon_prev[i] = light[i];
            end
        end
    end

    initial begin
        int lsum, bsum, l1sum;
        rst = 1'b1; button = '0; abort = 1'b0;
        button_m0 = '0; abort_m0 = 1'b0; button_p1 = '0;
        step(2);
        chk("rst_light", light, 0);
        chk("rst_busy", busy, 0);
        chk("rst_shots", shot_count, 0);
        rst = 1'b0;
        step(1);

        // 1: held press gives one 3-cycle pulse, 7 busy cycles, then waits for release
        button = 2'b01;
        expect_pulse(0, 3, 1);
        lsum = 0; bsum = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            lsum += int'(light[0]);
            bsum += int'(busy[0]);
        end
        chk("t1_light_cycles", lsum, 3);
        chk("t1_busy_cycles", bsum, 7);
        chk("t1_shots", shot_count, 1);
        step(3);
        chk("t1_wait_rel_light", light, 0);
        button = 2'b00;
        step(2);

        // 2: button held across reset must be released and re-pressed
        button = 2'b01;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);
        chk("t2_held_light", light, 0);
        chk("t2_held_shots", shot_count, 0);
        button = 2'b00;
        step(1);
        button = 2'b01;
        expect_pulse(0, 3, 1);
        step(1);
        chk("t2_repress_light", light, 1);
        step(8);
        button = 2'b00;
        step(2);

        // 3: simultaneous presses; MUTEX=1 lowest wins, MUTEX=0 both fire
        button = 2'b11;
        button_m0 = 2'b11;
        expect_pulse(0, 3, 2);
        step(1);
        chk("t3_mutex_light", light, 2'b01);
        chk("t3_nomutex_light", light_m0, 2'b11);
        chk("t3_nomutex_shots", shot_m0, 2);
        step(9);
        chk("t3_mutex_shots", shot_count, 2);
        chk("t3_loser_busy", busy[1], 0);
        button = 2'b00;
        button_m0 = 2'b00;
        step(2);

        // 4: abort in second FIRE cycle; press during abort dropped
        button = 2'b01;
        expect_pulse(0, 2, 3);
        step(2);
        chk("t4_fire2_light", light[0], 1);
        abort = 1'b1;
        step(1);
        chk("t4_abort_light", light[0], 0);
        button = 2'b11;
        bsum = 0; l1sum = 0;
        for (int k = 0; k < 6; k++) begin
            bsum  += int'(busy[0]);
            l1sum += int'(light[1]);
            step(1);
            if (k == 0) abort = 1'b0;
        end
        chk("t4_cool_busy", bsum, 4);
        chk("t4_press_in_abort", l1sum, 0);
        chk("t4_shots", shot_count, 3);
        button = 2'b00;
        step(2);

        // 5: re-press during cooldown dropped, press after IDLE fires
        button = 2'b01;
        expect_pulse(0, 3, 4);
        step(1);
        button = 2'b00;
        step(3);
        button = 2'b01;
        step(1);
        chk("t5_cool_press_shots", shot_count, 4);
        chk("t5_cool_press_light", light[0], 0);
        chk("t5_cool_busy", busy[0], 1);
        button = 2'b00;
        step(3);
        chk("t5_idle_busy", busy[0], 0);
        step(1);
        button = 2'b01;
        expect_pulse(0, 3, 5);
        step(1);
        chk("t5_refire_light", light[0], 1);
        chk("t5_refire_shots", shot_count, 5);
        button = 2'b00;
        step(8);

        // 6: single-cycle pulses, counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            button_p1 = 1'b1;
            step(1);
            if (i == 0) chk("t6_first_light", light_p1, 1);
            button_p1 = 1'b0;
            step(1);
            if (i == 0) chk("t6_one_cycle_pulse", light_p1, 0);
            step(5);
            if (i == 253) chk("t6_shots_254", shot_p1, 254);
        end
        chk("t6_shots_sat", shot_p1, 255);

        step(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
